dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and default parameters.
package dmem_arbiter_pkg;

  localparam int DW_DEF          = 32;
  localparam int AW_DEF          = 32;
  localparam int DEPTH_WORDS_DEF = 64;
  localparam int MAX_BURST_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the shared single-port data memory.
// Port 0 is the pipeline MEM stage, port 1 the loader/debug port. Each
// transaction takes IDLE (grant) -> ACCESS (strobe) -> RESP (ack).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int AW          = AW_DEF,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int MAX_BURST   = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic [1:0]    ack,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] burst_q, burst_d;
  logic          last_q;   // port granted most recently (1 = port 1)
  logic          win_q;    // port owning the in-flight transaction
  logic          bad_q;    // in-flight transaction is misaligned or out of range

  logic          any_req;
  logic          win1;
  logic          burst_full, burst_on;
  logic          sel_we, sel_bad;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Word-aligned and inside the memory, otherwise the access is refused.
  function automatic logic addr_invalid(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= AW'(DEPTH_WORDS));
  endfunction

  assign any_req = req0 | req1;

  // Arbitration: burst lock first, then round-robin on ties.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win1       = 1'b0;
    burst_d    = '0;
    burst_full = (burst_q == CW'(MAX_BURST));
    burst_on   = (burst_q != '0) && !burst_full;
    if (req0 && req1) begin
      if (burst_full)    win1 = 1'b0;
      else if (burst_on) win1 = 1'b1;
      else               win1 = !last_q;
    end else begin
      win1 = req1;
    end
    // A lone locked port 1 at the cap keeps winning; the count saturates.
    if (win1 && lock1) burst_d = burst_full ? burst_q : burst_q + CW'(1);
  end

  // Mux the winning port's request fields.
  always_comb begin
    sel_we    = win1 ? we1    : we0;
    sel_addr  = win1 ? addr1  : addr0;
    sel_wdata = win1 ? wdata1 : wdata0;
    sel_bad   = addr_invalid(sel_addr);
  end

  // Next-state logic: fixed three-cycle transaction.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Grant capture, memory strobes, read-data capture and response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q   <= '0;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      bad_q     <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack       <= 2'b00;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            win_q     <= win1;
            last_q    <= win1;
            burst_q   <= burst_d;
            bad_q     <= sel_bad;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_re    <= !sel_we && !sel_bad;
            mem_we    <= sel_we && !sel_bad;
          end
        end
        ACCESS: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          rdata  <= mem_re ? mem_rdata : '0;
          ack    <= win_q ? 2'b10 : 2'b01;
          err    <= bad_q;
        end
        RESP: begin
          ack <= 2'b00;
          err <= 1'b0;
        end
        default: begin
          ack <= 2'b00;
          err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic, compared cycle by cycle against a transaction-level model.
module tb_dmem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 64;
  localparam int MAXB  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]    ack;
  logic          err, mem_re, mem_we;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  // Shared memory: combinational read, write on clk edge, bench preload port.
  logic [DW-1:0] ram [DEPTH];
  logic [AW-1:0] ram_idx;
  logic          pl_en = 1'b0;
  logic [5:0]    pl_idx = '0;
  logic [DW-1:0] pl_data = '0;

  assign ram_idx   = mem_addr >> 2;
  assign mem_rdata = (ram_idx < AW'(DEPTH)) ? ram[ram_idx[5:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_data;
    else if (mem_we && ram_idx < AW'(DEPTH)) ram[ram_idx[5:0]] <= mem_wdata;
  end

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .lock1(lock1),
    .ack(ack), .err(err), .rdata(rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_phase;   // 0 waiting for grant, 1 memory access, 2 response
  bit            m_win, m_last, m_bad, m_we;
  int            m_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd;
  int            cyc;
  bit            saw_mem_we;
  int            ack_port[$];
  int            ack_cyc[$];

  function automatic bit is_bad(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= AW'(DEPTH));
  endfunction

  task automatic model_reset();
    m_phase = 0; m_last = 1'b1; m_cnt = 0;
  endtask

  task automatic model_grant();
    bit w;
    if (req0 && !req1)      w = 1'b0;
    else if (!req0 && req1) w = 1'b1;
    else if (m_cnt == MAXB) w = 1'b0;
    else if (m_cnt > 0)     w = 1'b1;
    else                    w = !m_last;
    if (w && lock1) m_cnt = (m_cnt < MAXB) ? m_cnt + 1 : MAXB;
    else            m_cnt = 0;
    m_last  = w;
    m_win   = w;
    m_we    = w ? we1 : we0;
    m_addr  = w ? addr1 : addr0;
    m_wdata = w ? wdata1 : wdata0;
    m_bad   = is_bad(m_addr);
  endtask

  // One clock: predict the edge from current inputs, then check outputs after it.
  task automatic tick();
    int nphase;
    nphase = 0;
    case (m_phase)
      0: if (req0 || req1) begin model_grant(); nphase = 1; end
      1: begin
        m_rd = '0;
        if (!m_bad) begin
          if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
          else      m_rd = ref_mem[m_addr[7:2]];
        end
        nphase = 2;
      end
      default: nphase = 0;
    endcase
    @(posedge clk); #1;
    m_phase = nphase;
    cyc++;
    if (mem_we) saw_mem_we = 1'b1;
    case (m_phase)
      0: begin
        check("idle_ack", ack, 2'b00);
        check("idle_strobe", {mem_re, mem_we}, 2'b00);
      end
      1: begin
        check("acc_re", mem_re, !m_we && !m_bad);
        check("acc_we", mem_we, m_we && !m_bad);
        check("acc_addr", mem_addr, m_addr);
        check("acc_wdata", mem_wdata, m_wdata);
        check("acc_ack", ack, 2'b00);
      end
      default: begin
        check("resp_ack", ack, m_win ? 2'b10 : 2'b01);
        check("resp_err", err, m_bad);
        check("resp_rdata", rdata, m_rd);
        check("resp_strobe", {mem_re, mem_we}, 2'b00);
        ack_port.push_back(int'(m_win));
        ack_cyc.push_back(cyc);
      end
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, ack, 2'b00);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_rdata"}, rdata, '0);
    check({tag, "_re"}, mem_re, 1'b0);
    check({tag, "_we"}, mem_we, 1'b0);
    check({tag, "_addr"}, mem_addr, '0);
    check({tag, "_wdata"}, mem_wdata, '0);
  endtask

  task automatic do_reset(input bit preload);
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock1 = 0;
    #1;
    check_all_zero("rst");
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) begin
        pl_en = 1'b1; pl_idx = 6'(i);
        pl_data = (i == 4) ? 32'hDEAD_BEEF : $urandom;
        ref_mem[i] = pl_data;
        @(posedge clk); #1;
      end
      pl_en = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    ack_port.delete();
    ack_cyc.delete();
  endtask

  // Single transaction on one port, then release the request.
  task automatic do_txn(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    repeat (3) tick();
    req0 = 0; req1 = 0;
    tick();
  endtask

  task automatic check_seq(input string tag, input int exp[]);
    check({tag, "_count"}, ack_port.size() >= exp.size(), 1'b1);
    for (int i = 0; i < exp.size() && i < ack_port.size(); i++) begin
      check(tag, ack_port[i], exp[i]);
      if (i > 0) check({tag, "_gap"}, ack_cyc[i] - ack_cyc[i-1], 3);
    end
  endtask

  // Random requester state.
  bit pend [2];

  task automatic drive_port(input bit p);
    logic [AW-1:0] a;
    bit            busy;
    busy = (m_phase != 0) && (m_win == p);
    if (m_phase == 2 && m_win == p) begin
      pend[p] = 0;
      if (p) req1 = 0; else req0 = 0;
    end
    if (!pend[p]) begin
      if ($urandom_range(2) == 0) begin
        case ($urandom_range(7))
          0:       a = AW'($urandom_range(DEPTH - 1) * 4 + $urandom_range(1, 3));
          1:       a = AW'(DEPTH * 4 + $urandom_range(255) * 4);
          default: a = AW'($urandom_range(DEPTH - 1) * 4);
        endcase
        pend[p] = 1;
        if (p) begin req1 = 1; we1 = 1'($urandom); addr1 = a; wdata1 = $urandom; end
        else   begin req0 = 1; we0 = 1'($urandom); addr0 = a; wdata0 = $urandom; end
      end
    end else if (!busy && $urandom_range(19) == 0) begin
      pend[p] = 0;   // withdraw before being granted
      if (p) req1 = 0; else req0 = 0;
    end
  endtask

  initial begin
    logic [DW-1:0] word8;
    cyc = 0;
    model_reset();
    do_reset(1'b1);

    // Single read of word 4.
    do_txn(1'b0, 1'b0, 32'h10, '0);
    check("read_port", ack_port.size() == 1 && ack_port[0] == 0, 1'b1);

    // Round-robin tie from reset.
    do_reset(1'b0);
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h20;
    repeat (12) tick();
    check_seq("tie", '{0, 1, 0, 1});

    // Locked burst from port 1.
    do_reset(1'b0);
    req0 = 1; req1 = 1; lock1 = 1;
    repeat (33) tick();
    check_seq("burst", '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1});
    req0 = 0; req1 = 0; lock1 = 0;
    repeat (3) tick();

    // Misaligned read and out-of-range write on port 1.
    saw_mem_we = 1'b0;
    ack_port.delete(); ack_cyc.delete();
    do_txn(1'b1, 1'b0, 32'h13, '0);
    do_txn(1'b1, 1'b1, 32'h100, 32'hCAFE_F00D);
    check("bad_we_seen", saw_mem_we, 1'b0);
    check("bad_acks", ack_port.size(), 2);

    // Reset during the ACCESS cycle of a write to word 8.
    word8 = ref_mem[8];
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h1234_5678;
    tick();
    check("midrst_in_access", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    req0 = 0; we0 = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ack_port.delete(); ack_cyc.delete();
    repeat (6) tick();
    check("midrst_no_ack", ack_port.size(), 0);
    check("midrst_word8", ram[8], word8);

    // Randomized traffic.
    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 1500; i++) begin
      drive_port(1'b0);
      drive_port(1'b1);
      if ($urandom_range(7) == 0) lock1 = ~lock1;
      tick();
    end
    req0 = 0; req1 = 0; lock1 = 0;
    repeat (4) tick();
    for (int i = 0; i < DEPTH; i++) check("final_mem", ram[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
